load_store_unit: RTL

Load/store unit between the MEM pipeline stage and the byte-addressed, big-endian data memory. Accepts one load or store request at a time, generates word-aligned memory reads and writes, performs read-modify-write for byte and halfword stores, and returns sign- or zero-extended load data. Drives the data memory's MemRead/MemWrite/dmem_address/write_data_mem inputs. Consumes its registered read_data one cycle after a read.

---
 rtl/mem_pkg.sv | 53 +++++
 rtl/lsu_align.sv | 82 ++++++++
 rtl/load_store_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and helpers for the load/store unit: memory
//                operation and FSM state encodings, default data-memory
//                size, and request classification helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Default data-memory size in bytes; addresses at or above are errors.
    localparam int unsigned c_DMEM_BYTES_DEFAULT = 2048;

    // Memory operation requested by the MEM stage.
    typedef enum logic [2:0] {
        LB  = 3'd0,
        LBU = 3'd1,
        LH  = 3'd2,
        LHU = 3'd3,
        LW  = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } mem_op_e;

    // Load/store unit sequencing states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        MERGE = 3'd2,
        WR    = 3'd3,
        ERR   = 3'd4
    } lsu_state_e;

    // True for any operation that writes memory.
    function automatic logic is_store(input mem_op_e op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    // True when the low address bits are not a legal offset for the access
    // width: halfwords must be even, words must be 4-byte aligned.
    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] lo);
        logic v_bad;
        case (op)
            LH, LHU, SH: v_bad = lo[0];
            LW, SW:      v_bad = |lo;
            default:     v_bad = 1'b0;
        endcase
        return v_bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational big-endian lane logic. Extracts and extends
//                the load value from a memory word, and builds the merged
//                word for sub-word stores.
//                Ports:
//                  i_op          operation being performed
//                  i_addr        byte offset within the word
//                  i_word        word read from memory
//                  i_wdata       right-justified store data
//                  o_load_data   extended load value (0 for stores)
//                  o_merged_word word to write back (store data for SW)
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import mem_pkg::*;
(
    input  mem_op_e     i_op,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Big-endian: offset 0 is the most significant byte of the word.
    always_comb begin
        w_byte = 8'd0;
        case (i_addr)
            2'd0: w_byte = i_word[31:24];
            2'd1: w_byte = i_word[23:16];
            2'd2: w_byte = i_word[15:8];
            2'd3: w_byte = i_word[7:0];
            default: w_byte = 8'd0;
        endcase
        w_half = i_addr[1] ? i_word[15:0] : i_word[31:16];
    end

    always_comb begin
        o_load_data = 32'd0;
        case (i_op)
            LB:      o_load_data = {{24{w_byte[7]}}, w_byte};
            LBU:     o_load_data = {24'd0, w_byte};
            LH:      o_load_data = {{16{w_half[15]}}, w_half};
            LHU:     o_load_data = {16'd0, w_half};
            LW:      o_load_data = i_word;
            default: o_load_data = 32'd0;
        endcase
    end

    // Sub-word stores overwrite only the addressed lane; the remaining lanes
    // come from the word just read.
    always_comb begin
        o_merged_word = i_word;
        case (i_op)
            SB: begin
                case (i_addr)
                    2'd0: o_merged_word[31:24] = i_wdata[7:0];
                    2'd1: o_merged_word[23:16] = i_wdata[7:0];
                    2'd2: o_merged_word[15:8]  = i_wdata[7:0];
                    2'd3: o_merged_word[7:0]   = i_wdata[7:0];
                    default: o_merged_word = i_word;
                endcase
            end
            SH: begin
                if (i_addr[1]) begin
                    o_merged_word[15:0] = i_wdata[15:0];
                end else begin
                    o_merged_word[31:16] = i_wdata[15:0];
                end
            end
            SW:      o_merged_word = i_wdata;
            default: o_merged_word = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Load/store unit between the MEM stage and a byte-addressed,
//                big-endian data memory with a registered read port. Handles
//                one request at a time, issues word-aligned reads/writes,
//                performs read-modify-write for SB/SH and returns extended
//                load data.
//                Ports:
//                  clk, rst                 clock, synchronous active-high reset
//                  req_valid/req_ready      request handshake
//                  req_op/req_addr/req_wdata request operation, address, data
//                  resp_valid/resp_rdata/resp_err  one-cycle completion
//                  MemRead/MemWrite         data-memory strobes
//                  dmem_address             word-aligned memory address
//                  write_data_mem           word written to memory
//                  read_data                memory word, valid after MemRead
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import mem_pkg::*;
#(
    parameter int unsigned DMEM_BYTES = c_DMEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] dmem_address,
    output logic [31:0] write_data_mem,
    input  logic [31:0] read_data
);

    localparam logic [31:0] c_ADDR_LIMIT = 32'(DMEM_BYTES);

    lsu_state_e  r_state;
    mem_op_e     r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merged;

    mem_op_e     w_req_op;
    logic        w_req_err;
    logic        w_is_load;
    logic [31:0] w_load_data;
    logic [31:0] w_merged_word;

    assign w_req_op  = mem_op_e'(req_op);
    assign w_req_err = is_misaligned(w_req_op, req_addr[1:0]) ||
                       (req_addr >= c_ADDR_LIMIT);
    assign w_is_load = !is_store(r_op);

    // Lane logic works on the captured request and the returned word only.
    lsu_align u_align (
        .i_op          (r_op),
        .i_addr        (r_addr[1:0]),
        .i_word        (read_data),
        .i_wdata       (r_wdata),
        .o_load_data   (w_load_data),
        .o_merged_word (w_merged_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= LB;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_merged <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_op    <= w_req_op;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        if (w_req_err) begin
                            r_state <= ERR;
                        end else if (w_req_op == SW) begin
                            // Full-word store needs no read of the old word.
                            r_state <= WR;
                        end else begin
                            r_state <= RD;
                        end
                    end
                end
                RD: begin
                    r_state <= MERGE;
                end
                MERGE: begin
                    if (w_is_load) begin
                        r_state <= IDLE;
                    end else begin
                        r_merged <= w_merged_word;
                        r_state  <= WR;
                    end
                end
                WR:      r_state <= IDLE;
                ERR:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // All outputs decode from the state and captured registers, so the
    // memory side never sees the raw request inputs. Because the captured
    // address/data only change on acceptance, dmem_address and
    // write_data_mem hold their last values while idle.
    assign req_ready      = (r_state == IDLE);
    assign MemRead        = (r_state == RD);
    assign MemWrite       = (r_state == WR);
    assign dmem_address   = {r_addr[31:2], 2'b00};
    assign write_data_mem = (r_op == SW) ? r_wdata : r_merged;

    assign resp_valid = ((r_state == MERGE) && w_is_load) ||
                        (r_state == WR) || (r_state == ERR);
    assign resp_err   = (r_state == ERR);
    // read_data is only meaningful in MERGE, so loads complete there.
    assign resp_rdata = ((r_state == MERGE) && w_is_load) ? w_load_data : 32'd0;

endmodule
`default_nettype wire
